// File: rtl/rv_imem_if.sv
// rv_imem fetch/load bus: core fetch request/response plus load-port write.
// master = core/loader side, slave = rv_imem side.
interface rv_imem_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        we_i;
  logic [31:0] waddr_i;
  logic [31:0] wdata_i;

  modport master (
    output req_i, addr_i, we_i, waddr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, waddr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/rv_imem.sv
// rv_imem: instruction memory responder, one outstanding fetch, fixed latency.
// Ports: clk_i, rst_ni (async low), bus (rv_imem_if.slave: req/addr/gnt,
// rvalid/rdata/err, we/waddr/wdata load port).
// Option: RV_IMEM_ALIGN_CHECK_EN flags misaligned fetches on err_o.
module rv_imem #(
  parameter int          DEPTH       = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  rv_imem_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_buf;
  logic        r_berr;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_rvalid;
  logic [31:0] r_mem [DEPTH];

  logic          w_gnt;
  logic          w_mis;
  logic [AW-1:0] w_ridx;
  logic [AW-1:0] w_widx;
  logic [31:0]   w_rd;

  assign w_ridx = bus.addr_i[AW+1:2];
  assign w_widx = bus.waddr_i[AW+1:2];
  assign w_rd   = r_mem[w_ridx];

`ifdef RV_IMEM_ALIGN_CHECK_EN
  assign w_mis = |bus.addr_i[1:0];
`else
  assign w_mis = 1'b0;
`endif

  assign w_gnt = rst_ni & bus.req_i &
                 ((r_state == S_IDLE) | (r_state == S_RESP));

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;
  assign bus.err_o    = r_err;

  // Word is captured at the grant edge (read-first) into r_buf so that
  // rdata_o only changes when the response is presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_berr   <= 1'b0;
      r_rdata  <= RESET_INSTR;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_gnt) begin
        r_buf  <= w_rd;
        r_berr <= w_mis;
        r_cnt  <= LAT_M1;
        if (LATENCY == 1) begin
          r_state  <= S_RESP;
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd;
          r_err    <= w_mis;
        end else begin
          r_state <= S_WAIT;
        end
      end else begin
        case (r_state)
          S_WAIT: begin
            if (r_cnt == 2'd1) begin
              r_state  <= S_RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= r_buf;
              r_err    <= r_berr;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Program memory is not reset.
  always_ff @(posedge clk_i) begin
    if (bus.we_i) r_mem[w_widx] <= bus.wdata_i;
  end

endmodule

// File: tb/tb_rv_imem.sv
// tb_rv_imem: scoreboard bench for rv_imem, LATENCY=1 and LATENCY=3 instances.
// Expected words come from a bench-side memory model.
module tb_rv_imem;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rv_imem_if if1 ();
  rv_imem_if if3 ();

  rv_imem #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if1)
  );

  rv_imem #(.DEPTH(1024), .LATENCY(3)) u_dut3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if3)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] mdl [1024];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a);
`ifdef RV_IMEM_ALIGN_CHECK_EN
    return |a[1:0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input int lat);
    exp_t x;
    x.d   = mdl[a[11:2]];
    x.e   = exp_err(a);
    x.due = cyc + lat;
    return x;
  endfunction

  // Monitor: pop/compare responses, push expectations on grants,
  // then apply the load-port write to the model (read-first).
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (if1.rvalid_o) begin
        if (q1.size() == 0) chk("rv1_spurious", 1, 0);
        else begin
          e = q1.pop_front();
          chk("rdata1", if1.rdata_o, e.d);
          chk("err1", 32'(if1.err_o), 32'(e.e));
          chk("due1", cyc, e.due);
        end
      end
      if (if3.rvalid_o) begin
        if (q3.size() == 0) chk("rv3_spurious", 1, 0);
        else begin
          e = q3.pop_front();
          chk("rdata3", if3.rdata_o, e.d);
          chk("err3", 32'(if3.err_o), 32'(e.e));
          chk("due3", cyc, e.due);
        end
      end
      if (if1.gnt_o) q1.push_back(mk(if1.addr_i, 1));
      if (if3.gnt_o) q3.push_back(mk(if3.addr_i, 3));
      if (if1.we_i) mdl[if1.waddr_i[11:2]] = if1.wdata_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    if1.we_i = 1'b1; if1.waddr_i = a; if1.wdata_i = d;
    if3.we_i = 1'b1; if3.waddr_i = a; if3.wdata_i = d;
    step();
    if1.we_i = 1'b0;
    if3.we_i = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a);
    if1.req_i = 1'b1; if1.addr_i = a;
    step();
    if1.req_i = 1'b0;
  endtask

  task automatic fetch3(input logic [31:0] a);
    if3.req_i = 1'b1; if3.addr_i = a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if3.gnt_o) break;
    end
    chk("gnt3_wait", 32'(if3.gnt_o), 1);
    step();
    if3.req_i = 1'b0;
  endtask

  initial begin
    if1.req_i = 0; if1.addr_i = 0; if1.we_i = 0;
    if1.waddr_i = 0; if1.wdata_i = 0;
    if3.req_i = 0; if3.addr_i = 0; if3.we_i = 0;
    if3.waddr_i = 0; if3.wdata_i = 0;
    #2 rst_n = 1'b0;
    if1.req_i = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(if1.gnt_o), 0);
    chk("rst_rvalid", 32'(if1.rvalid_o), 0);
    chk("rst_err", 32'(if1.err_o), 0);
    chk("rst_rdata", if1.rdata_o, 32'h0000_0013);
    step();
    if1.req_i = 1'b0;
    rst_n = 1'b1;

    wr(32'h0, 32'h0050_0093);
    wr(32'h4, 32'h0000_0113);
    wr(32'h8, 32'hA5A5_0002);
    wr(32'hC, 32'h1234_5678);

    // back-to-back fetches at latency 1
    if1.req_i = 1'b1; if1.addr_i = 32'h0;
    @(negedge clk);
    chk("b2b_gnt0", 32'(if1.gnt_o), 1);
    step();
    if1.addr_i = 32'h4;
    @(negedge clk);
    chk("b2b_gnt1", 32'(if1.gnt_o), 1);
    step();
    if1.req_i = 1'b0;
    repeat (2) step();

    // latency 3: no grant while waiting
    if3.req_i = 1'b1; if3.addr_i = 32'h8;
    @(negedge clk);
    chk("l3_gnt", 32'(if3.gnt_o), 1);
    step();
    @(negedge clk);
    chk("l3_wait1", 32'(if3.gnt_o), 0);
    step();
    @(negedge clk);
    chk("l3_wait2", 32'(if3.gnt_o), 0);
    step();
    if3.req_i = 1'b0;
    repeat (3) step();

    // read-first on the grant edge
    if1.req_i = 1'b1; if1.addr_i = 32'hC;
    if1.we_i = 1'b1; if1.waddr_i = 32'hC; if1.wdata_i = 32'hDEAD_BEEF;
    if3.we_i = 1'b1; if3.waddr_i = 32'hC; if3.wdata_i = 32'hDEAD_BEEF;
    step();
    if1.req_i = 1'b0; if1.we_i = 1'b0; if3.we_i = 1'b0;
    repeat (2) step();
    fetch1(32'hC);
    repeat (2) step();

    // aliasing
    fetch1(32'h0000_1004);
    repeat (2) step();

    // misaligned fetch
    fetch1(32'h0000_0006);
    repeat (2) step();

    // a few latency-3 fetches, one misaligned
    fetch3(32'h0);
    fetch3(32'h4);
    fetch3(32'h0000_200D);
    fetch3(32'hC);
    repeat (4) step();

    // random back-to-back latency-1 fetches
    for (int i = 0; i < 8; i++) begin
      if1.req_i = 1'b1;
      if1.addr_i = 32'($urandom_range(0, 15));
      step();
    end
    if1.req_i = 1'b0;
    repeat (2) step();

    // reset during WAIT drops the fetch
    if3.req_i = 1'b1; if3.addr_i = 32'h8;
    step();
    if3.req_i = 1'b0;
    rst_n = 1'b0;
    q3.delete();
    @(negedge clk);
    chk("rstw_rvalid", 32'(if3.rvalid_o), 0);
    chk("rstw_rdata", if3.rdata_o, 32'h0000_0013);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rstw_rdata_post", if3.rdata_o, 32'h0000_0013);

    repeat (3) step();
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule
